// File: rtl/alarm_clock_ctrl_pkg.sv
// Shared types for the alarm clock controller: state encoding, LED codes and
// button arbitration.
package alarm_clock_pkg;

  // state     | meaning
  // S_DISP    | show time, alarms armed
  // S_SET_HR  | edit time hours, time frozen
  // S_SET_MIN | edit time minutes, time frozen
  // S_ALM_SEL | pick slot, toggle its enable
  // S_ALM_HR  | edit selected slot hour
  // S_ALM_MIN | edit selected slot minute
  // S_RING    | alarm sounding
  typedef enum logic [2:0] {
    S_DISP    = 3'd0,
    S_SET_HR  = 3'd1,
    S_SET_MIN = 3'd2,
    S_ALM_SEL = 3'd3,
    S_ALM_HR  = 3'd4,
    S_ALM_MIN = 3'd5,
    S_RING    = 3'd6
  } state_e;

  localparam logic [4:0] LED_DISP    = 5'b00000;
  localparam logic [4:0] LED_SET_HR  = 5'b11000;
  localparam logic [4:0] LED_SET_MIN = 5'b10100;
  localparam logic [4:0] LED_ALM_SEL = 5'b10010;
  localparam logic [4:0] LED_ALM_HR  = 5'b10001;
  localparam logic [4:0] LED_ALM_MIN = 5'b10011;
  localparam logic [4:0] LED_RING    = 5'b11111;

  typedef enum logic [2:0] {
    BTN_NONE = 3'd0,
    BTN_C    = 3'd1,
    BTN_L    = 3'd2,
    BTN_R    = 3'd3,
    BTN_U    = 3'd4,
    BTN_D    = 3'd5
  } btn_e;

  // Only one button is honoured per cycle: C > L > R > U > D.
  function automatic btn_e pick_btn(input logic c, input logic l, input logic r,
                                    input logic u, input logic d);
    if (c) return BTN_C;
    if (l) return BTN_L;
    if (r) return BTN_R;
    if (u) return BTN_U;
    if (d) return BTN_D;
    return BTN_NONE;
  endfunction

  function automatic logic [4:0] mode_led_of(input state_e s);
    case (s)
      S_SET_HR:  return LED_SET_HR;
      S_SET_MIN: return LED_SET_MIN;
      S_ALM_SEL: return LED_ALM_SEL;
      S_ALM_HR:  return LED_ALM_HR;
      S_ALM_MIN: return LED_ALM_MIN;
      S_RING:    return LED_RING;
      default:   return LED_DISP;
    endcase
  endfunction

endpackage

// File: rtl/alarm_clock_ctrl_bcd_hm_counter.sv
// Combinational BCD digit-pair stepper for hours (mod 24) or minutes (mod 60).
// carry_o flags an increment that wrapped to 00.
module bcd_hm_counter #(
  parameter int MODULUS = 60,
  parameter int TW      = (MODULUS == 24) ? 2 : 3
) (
  input  logic [TW-1:0] tens_i,
  input  logic [3:0]    units_i,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [TW-1:0] tens_o,
  output logic [3:0]    units_o,
  output logic          carry_o
);

  localparam logic [TW-1:0] MAX_T = TW'((MODULUS - 1) / 10);
  localparam logic [3:0]    MAX_U = 4'((MODULUS - 1) % 10);

  always_comb begin
    tens_o  = tens_i;
    units_o = units_i;
    carry_o = 1'b0;
    if (inc_i) begin
      if (tens_i == MAX_T && units_i == MAX_U) begin
        tens_o  = '0;
        units_o = '0;
        carry_o = 1'b1;
      end else if (units_i == 4'd9) begin
        tens_o  = tens_i + 1'b1;
        units_o = '0;
      end else begin
        units_o = units_i + 4'd1;
      end
    end else if (dec_i) begin
      if (tens_i == '0 && units_i == '0) begin
        tens_o  = MAX_T;
        units_o = MAX_U;
      end else if (units_i == '0) begin
        tens_o  = tens_i - 1'b1;
        units_o = 4'd9;
      end else begin
        units_o = units_i - 4'd1;
      end
    end
  end

endmodule

// File: rtl/alarm_clock_ctrl.sv
// Multi-alarm BCD clock: 1 Hz prescaler, time-of-day, alarm slots, button
// edit FSM, snooze and ring timeout.
module alarm_clock_ctrl
  import alarm_clock_pkg::*;
#(
  parameter int NUM_ALARMS     = 4,
  parameter int TICK_DIV       = 200,
  parameter int SNOOZE_MIN     = 5,
  parameter int RING_TIMEOUT_S = 60,
  localparam int IW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk_200_hz,
  input  logic                  rst,
  input  logic                  btn_u,
  input  logic                  btn_d,
  input  logic                  btn_l,
  input  logic                  btn_r,
  input  logic                  btn_c,
  output logic [1:0]            hr_tens,
  output logic [3:0]            hr_units,
  output logic [2:0]            min_tens,
  output logic [3:0]            min_units,
  output logic [5:0]            sec,
  output logic                  blink,
  output logic                  ring,
  output logic [4:0]            mode_led,
  output logic [IW-1:0]         alm_idx,
  output logic [NUM_ALARMS-1:0] alm_en
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RW = $clog2(RING_TIMEOUT_S + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_ALARMS - 1);
  localparam logic [3:0]    SNZ_U    = 4'(SNOOZE_MIN % 10);
  localparam logic [2:0]    SNZ_T    = 3'(SNOOZE_MIN / 10);

  state_e                state_q, state_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic                  blink_q;
  logic [5:0]            sec_q, sec_d;
  logic [1:0]            hr_t_q, hr_t_d;
  logic [3:0]            hr_u_q, hr_u_d;
  logic [2:0]            min_t_q, min_t_d;
  logic [3:0]            min_u_q, min_u_d;
  logic [1:0]            ah_t_q [NUM_ALARMS];
  logic [3:0]            ah_u_q [NUM_ALARMS];
  logic [2:0]            am_t_q [NUM_ALARMS];
  logic [3:0]            am_u_q [NUM_ALARMS];
  logic [1:0]            ah_t_d;
  logic [3:0]            ah_u_d, am_u_d;
  logic [2:0]            am_t_d;
  logic [NUM_ALARMS-1:0] alm_en_q, alm_en_d;
  logic [IW-1:0]         alm_idx_q, alm_idx_d;
  logic [1:0]            snz_ht_q, snz_ht_d, snz_ht_n;
  logic [3:0]            snz_hu_q, snz_hu_d, snz_hu_n, snz_mu_q, snz_mu_d, snz_mu_n;
  logic [2:0]            snz_mt_q, snz_mt_d, snz_mt_n;
  logic                  snz_vld_q, snz_vld_d;
  logic [RW-1:0]         ring_cnt_q, ring_cnt_d;

  btn_e       btn;
  logic       sec_tick, tick_en, sec_wrap, min_carry, match_any, hit, alm_view;
  logic [4:0] snz_usum;
  logic [3:0] snz_tsum;
  logic       snz_uc, snz_hc;
  logic       hr_carry_unused, ah_carry_unused, am_carry_unused, sh_carry_unused;

  assign btn      = pick_btn(btn_c, btn_l, btn_r, btn_u, btn_d);
  assign sec_tick = (presc_q == PW'(TICK_DIV - 1));
  assign presc_d  = sec_tick ? '0 : presc_q + 1'b1;
  assign tick_en  = sec_tick && (state_q != S_SET_HR) && (state_q != S_SET_MIN);
  assign sec_wrap = tick_en && (sec_q == 6'd59);

  bcd_hm_counter #(.MODULUS(60)) u_min (
    .tens_i(min_t_q), .units_i(min_u_q),
    .inc_i(sec_wrap || (state_q == S_SET_MIN && btn == BTN_U)),
    .dec_i(state_q == S_SET_MIN && btn == BTN_D),
    .tens_o(min_t_d), .units_o(min_u_d), .carry_o(min_carry)
  );

  bcd_hm_counter #(.MODULUS(24)) u_hr (
    .tens_i(hr_t_q), .units_i(hr_u_q),
    .inc_i((sec_wrap && min_carry) || (state_q == S_SET_HR && btn == BTN_U)),
    .dec_i(state_q == S_SET_HR && btn == BTN_D),
    .tens_o(hr_t_d), .units_o(hr_u_d), .carry_o(hr_carry_unused)
  );

  bcd_hm_counter #(.MODULUS(24)) u_alm_hr (
    .tens_i(ah_t_q[alm_idx_q]), .units_i(ah_u_q[alm_idx_q]),
    .inc_i(state_q == S_ALM_HR && btn == BTN_U),
    .dec_i(state_q == S_ALM_HR && btn == BTN_D),
    .tens_o(ah_t_d), .units_o(ah_u_d), .carry_o(ah_carry_unused)
  );

  bcd_hm_counter #(.MODULUS(60)) u_alm_min (
    .tens_i(am_t_q[alm_idx_q]), .units_i(am_u_q[alm_idx_q]),
    .inc_i(state_q == S_ALM_MIN && btn == BTN_U),
    .dec_i(state_q == S_ALM_MIN && btn == BTN_D),
    .tens_o(am_t_d), .units_o(am_u_d), .carry_o(am_carry_unused)
  );

  // Snooze target: current minutes + SNOOZE_MIN in BCD, carrying into the hour.
  always_comb begin
    snz_usum = {1'b0, min_u_q} + {1'b0, SNZ_U};
    snz_uc   = (snz_usum >= 5'd10);
    snz_mu_n = snz_uc ? 4'(snz_usum - 5'd10) : snz_usum[3:0];
    snz_tsum = {1'b0, min_t_q} + {1'b0, SNZ_T} + {3'b000, snz_uc};
    snz_hc   = (snz_tsum >= 4'd6);
    snz_mt_n = snz_hc ? 3'(snz_tsum - 4'd6) : snz_tsum[2:0];
  end

  bcd_hm_counter #(.MODULUS(24)) u_snz_hr (
    .tens_i(hr_t_q), .units_i(hr_u_q), .inc_i(snz_hc), .dec_i(1'b0),
    .tens_o(snz_ht_n), .units_o(snz_hu_n), .carry_o(sh_carry_unused)
  );

  always_comb begin
    match_any = 1'b0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (alm_en_q[i] && ah_t_q[i] == hr_t_d && ah_u_q[i] == hr_u_d &&
          am_t_q[i] == min_t_d && am_u_q[i] == min_u_d)
        match_any = 1'b1;
    end
    if (snz_vld_q && snz_ht_q == hr_t_d && snz_hu_q == hr_u_d &&
        snz_mt_q == min_t_d && snz_mu_q == min_u_d)
      match_any = 1'b1;
  end

  // Any button in the rollover cycle takes precedence and the match is dropped.
  assign hit = sec_wrap && (state_q == S_DISP) && (btn == BTN_NONE) && match_any;

  always_comb begin
    state_d    = state_q;
    sec_d      = sec_q;
    alm_idx_d  = alm_idx_q;
    alm_en_d   = alm_en_q;
    snz_ht_d   = snz_ht_q;
    snz_hu_d   = snz_hu_q;
    snz_mt_d   = snz_mt_q;
    snz_mu_d   = snz_mu_q;
    snz_vld_d  = snz_vld_q;
    ring_cnt_d = ring_cnt_q;
    if (tick_en) sec_d = (sec_q == 6'd59) ? '0 : sec_q + 6'd1;
    case (state_q)
      S_DISP: begin
        if (btn == BTN_C) state_d = S_SET_HR;
        else if (btn == BTN_L) state_d = S_ALM_SEL;
        else if (hit) begin
          state_d    = S_RING;
          ring_cnt_d = RW'(RING_TIMEOUT_S);
          snz_vld_d  = 1'b0;
        end
      end
      S_SET_HR: begin
        if (btn == BTN_C) state_d = S_DISP;
        else if (btn == BTN_R) state_d = S_SET_MIN;
      end
      S_SET_MIN: begin
        if (btn == BTN_C) state_d = S_DISP;
        else if (btn == BTN_L) state_d = S_SET_HR;
      end
      S_ALM_SEL: begin
        case (btn)
          BTN_C: state_d = S_ALM_HR;
          BTN_L: state_d = S_DISP;
          BTN_R: alm_en_d[alm_idx_q] = ~alm_en_q[alm_idx_q];
          BTN_U: alm_idx_d = (alm_idx_q == LAST_IDX) ? '0 : alm_idx_q + 1'b1;
          BTN_D: alm_idx_d = (alm_idx_q == '0) ? LAST_IDX : alm_idx_q - 1'b1;
          default: ;
        endcase
      end
      S_ALM_HR: begin
        if (btn == BTN_C) state_d = S_ALM_SEL;
        else if (btn == BTN_R) state_d = S_ALM_MIN;
      end
      S_ALM_MIN: begin
        if (btn == BTN_C) begin
          state_d             = S_ALM_SEL;
          alm_en_d[alm_idx_q] = 1'b1;
        end else if (btn == BTN_L) state_d = S_ALM_HR;
      end
      S_RING: begin
        if (btn == BTN_C) state_d = S_DISP;
        else if (btn != BTN_NONE) begin
          state_d   = S_DISP;
          snz_ht_d  = snz_ht_n;
          snz_hu_d  = snz_hu_n;
          snz_mt_d  = snz_mt_n;
          snz_mu_d  = snz_mu_n;
          snz_vld_d = 1'b1;
        end else if (sec_tick) begin
          if (ring_cnt_q <= RW'(1)) state_d = S_DISP;
          else ring_cnt_d = ring_cnt_q - 1'b1;
        end
      end
      default: state_d = S_DISP;
    endcase
    if (state_d == S_SET_HR) sec_d = '0;
  end

  always_ff @(posedge clk_200_hz or posedge rst) begin
    if (rst) begin
      state_q    <= S_DISP;
      presc_q    <= '0;
      blink_q    <= 1'b0;
      sec_q      <= '0;
      hr_t_q     <= '0;
      hr_u_q     <= '0;
      min_t_q    <= '0;
      min_u_q    <= '0;
      alm_en_q   <= '0;
      alm_idx_q  <= '0;
      snz_ht_q   <= '0;
      snz_hu_q   <= '0;
      snz_mt_q   <= '0;
      snz_mu_q   <= '0;
      snz_vld_q  <= 1'b0;
      ring_cnt_q <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        ah_t_q[i] <= '0;
        ah_u_q[i] <= '0;
        am_t_q[i] <= '0;
        am_u_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      blink_q    <= (presc_d < PW'(TICK_DIV / 2));
      sec_q      <= sec_d;
      hr_t_q     <= hr_t_d;
      hr_u_q     <= hr_u_d;
      min_t_q    <= min_t_d;
      min_u_q    <= min_u_d;
      alm_en_q   <= alm_en_d;
      alm_idx_q  <= alm_idx_d;
      snz_ht_q   <= snz_ht_d;
      snz_hu_q   <= snz_hu_d;
      snz_mt_q   <= snz_mt_d;
      snz_mu_q   <= snz_mu_d;
      snz_vld_q  <= snz_vld_d;
      ring_cnt_q <= ring_cnt_d;
      if (state_q == S_ALM_HR) begin
        ah_t_q[alm_idx_q] <= ah_t_d;
        ah_u_q[alm_idx_q] <= ah_u_d;
      end
      if (state_q == S_ALM_MIN) begin
        am_t_q[alm_idx_q] <= am_t_d;
        am_u_q[alm_idx_q] <= am_u_d;
      end
    end
  end

  assign alm_view  = (state_q == S_ALM_HR) || (state_q == S_ALM_MIN);
  assign hr_tens   = alm_view ? ah_t_q[alm_idx_q] : hr_t_q;
  assign hr_units  = alm_view ? ah_u_q[alm_idx_q] : hr_u_q;
  assign min_tens  = alm_view ? am_t_q[alm_idx_q] : min_t_q;
  assign min_units = alm_view ? am_u_q[alm_idx_q] : min_u_q;
  assign sec       = sec_q;
  assign blink     = blink_q;
  assign ring      = (state_q == S_RING);
  assign mode_led  = mode_led_of(state_q);
  assign alm_idx   = alm_idx_q;
  assign alm_en    = alm_en_q;

endmodule

// File: doc/alarm_clock_ctrl.md
Name: alarm_clock_ctrl

Overview:
Multi-alarm digital clock controller for the 4-digit seven-segment board design. It keeps BCD time-of-day from an internal 1 Hz prescaler and holds NUM_ALARMS independently enabled alarm slots. It runs a button-driven edit FSM with snooze and ring timeout. It feeds the existing seven-segment mux and LEDs; button inputs come from the existing debounced single-pulse detectors.

Parameters:
NUM_ALARMS, 4, number of alarm slots (1..8)
TICK_DIV, 200, clk_200_hz cycles per second (sim uses 4)
SNOOZE_MIN, 5, snooze delay in minutes (1..59)
RING_TIMEOUT_S, 60, seconds of ringing before auto-dismiss

Ports:
clk_200_hz  in  1  system clock
rst  in  1  asynchronous, active-high reset
btn_u, btn_d, btn_l, btn_r, btn_c  in  1 each  one-cycle debounced pulses
hr_tens  out  2  displayed hour tens (BCD)
hr_units  out  4  displayed hour units
min_tens  out  3  displayed minute tens
min_units  out  4  displayed minute units
sec  out  6  current seconds, binary 0..59
blink  out  1  1 Hz square wave, high for the first half of each second
ring  out  1  alarm active
mode_led  out  5  state indicator
alm_idx  out  clog2(NUM_ALARMS)  selected slot
alm_en  out  NUM_ALARMS  per-slot enable mask

Behaviour:
- Reset, asynchronous, active-high; clock clk_200_hz. Reset values: time 00:00:00, all slots 00:00 and disabled, snooze invalid, state DISP, ring=0, blink=0, alm_idx=0, prescaler=0, mode_led=00000.
- Prescaler counts 0..TICK_DIV-1. sec_tick is a one-cycle pulse when the count wraps. blink=1 while count < TICK_DIV/2.
- Timekeeping on sec_tick: 59 s -> 0 increments minutes; 59 min -> 0 increments hours; 23:59:59 -> 00:00:00.
- Time is frozen in SET_HR and SET_MIN. sec is forced to 0 on entering SET_HR. Ticks continue in all other states.
- States and mode_led values:
  DISP = 00000, SET_HR = 11000, SET_MIN = 10100, ALM_SEL = 10010, ALM_HR = 10001, ALM_MIN = 10011, RING = 11111.
- Transitions. Only one button is acted on per cycle, priority C > L > R > U > D.
  DISP: C -> SET_HR; L -> ALM_SEL.
  SET_HR: U/D increments/decrements hours mod 24 (23 + 1 = 00, 00 - 1 = 23); R -> SET_MIN; C -> DISP.
  SET_MIN: U/D increments/decrements minutes mod 60; L -> SET_HR; C -> DISP.
  ALM_SEL: U/D changes alm_idx mod NUM_ALARMS; R toggles alm_en[alm_idx]; C -> ALM_HR; L -> DISP.
  ALM_HR: U/D edits the slot hour; R -> ALM_MIN; C -> ALM_SEL.
  ALM_MIN: U/D edits the slot minute; L -> ALM_HR; C -> ALM_SEL and sets alm_en[alm_idx]=1.
  RING: C dismisses -> DISP. Any other button snoozes: snooze target = now + SNOOZE_MIN (mod 24 h), snooze valid, -> DISP. Ring timer reaching RING_TIMEOUT_S dismisses -> DISP.
- Alarm match:
  - Evaluated only in DISP, in the cycle where sec_tick rolls sec to 0.
  - Fires when the new hh:mm equals any enabled slot, or the valid snooze target. Result: -> RING, ring timer cleared, snooze invalidated.
  - Multiple simultaneous matches give a single RING.
  - A match that occurs while in any edit state is lost, not deferred.
  - A button pulse and a match in the same DISP cycle: the button wins and the match is lost.
- ring = 1 only in RING. Registered; asserts the cycle after the match.
- Display mux: in ALM_HR/ALM_MIN, digits show slot alm_idx; otherwise they show current time. Digit outputs are combinational from registers.
- All arithmetic is on BCD digit pairs. Hour units never exceed 3 when tens = 2.

Decomposition:
- Package alarm_clock_pkg holds: the state encoding localparams, the mode_led codes, and the button-priority order.
- Sub-module bcd_hm_counter: a BCD hour/minute pair with inc, dec and carry-out, selectable modulus (24 or 60). It is instantiated for time hours, time minutes, and the edit datapath of the alarm slot.

Test Plan:
- Reset mid-count (TICK_DIV=4) -> all outputs at reset values next cycle; time counting resumes from 00:00:00.
- Preset time 23:59:58, wait 2 ticks -> 00:00:00, alarms silent.
- DISP, C, then U ×25 -> hours 01. Then R, D ×1 -> minutes 59. Then C -> DISP showing 01:59:00, counting resumes.
- ALM_SEL: U to slot 2, C, set 00:01, C -> alm_en = 0100. From 00:00:59, tick -> ring=1, mode_led=11111 next cycle.
- In RING, btn_u -> DISP, ring=0. Ring again exactly SNOOZE_MIN=5 minutes later at 00:06:00. Then no button for 60 s -> auto-dismiss to DISP.
- Slot disabled via R toggle at matching time -> no ring. btn_c and sec rollover to a match in the same DISP cycle -> SET_HR entered, ring stays 0.
